// File: rtl/memory_dumper.sv
// Scans an inclusive, wrap-around address range through a synchronous-read memory
// and streams {address, data} pairs over valid/ready while accumulating an 8-bit checksum.
module memory_dumper #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic       clock,
  input  logic       reset_N,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] start_adrs,
  input  logic [7:0] end_adrs,
  input  logic [7:0] mm_data,
  output logic [7:0] dm_adrs,
  output logic       dm_active,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_adrs,
  output logic [7:0] out_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] checksum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t     state, next_state;
  logic [7:0] end_q;
  logic [1:0] wait_cnt;

  logic handshake;
  logic last_byte;

  assign handshake = (state == S_PRESENT) && out_ready && !abort;
  assign last_byte = (dm_adrs == end_q);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) state <= S_IDLE;
    else          state <= next_state;
  end

  // NOTE: next_state and every output get a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    out_valid  = 1'b0;
    dm_active  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) next_state = S_ADDR;
      end
      S_ADDR: begin
        dm_active  = 1'b1;
        next_state = S_WAIT;
      end
      S_WAIT: begin
        dm_active = 1'b1;
        if (wait_cnt == 2'd0) next_state = S_PRESENT;
      end
      S_PRESENT: begin
        dm_active = 1'b1;
        out_valid = 1'b1;
        if (out_ready) next_state = last_byte ? S_DONE : S_ADDR;
      end
      S_DONE: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
    // Abort outranks everything, including a same-cycle handshake.
    if (abort && state != S_IDLE) next_state = S_IDLE;
  end

  // NOTE: end_q is a plain register, not a memory, so it is reset along with the rest of the datapath.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      dm_adrs  <= 8'h00;
      end_q    <= 8'h00;
      wait_cnt <= 2'd0;
      out_adrs <= 8'h00;
      out_data <= 8'h00;
      checksum <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            dm_adrs  <= start_adrs;
            end_q    <= end_adrs;
            checksum <= 8'h00;
          end
        end
        S_ADDR: begin
          wait_cnt <= 2'(RD_LAT - 1);
        end
        S_WAIT: begin
          if (!abort) begin
            if (wait_cnt == 2'd0) begin
              out_data <= mm_data;
              out_adrs <= dm_adrs;
            end else begin
              wait_cnt <= wait_cnt - 2'd1;
            end
          end
        end
        S_PRESENT: begin
          if (handshake) begin
            checksum <= checksum + out_data;
            if (!last_byte) dm_adrs <= dm_adrs + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
